// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: widths, field positions, FSM states and the reset vector.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam int OP_LSB     = 0;
    localparam int OP_MSB     = 6;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetched {pc, inst} entries; flush empties it in one cycle.
module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_MAX = DEPTH;

    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A flush overrides any same-cycle push or pop.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues one imem request at a time and buffers words for decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_rvalid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic        fetch_misalign
);

    localparam int              CW      = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW-1:0]   CNT_MAX = BUF_DEPTH;
    localparam logic [XLEN-1:0] PC_STEP = 4;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            req_q, req_d;
    logic            misalign_q, misalign_d;

    logic                   push, pop, can_issue;
    logic [XLEN+ILEN-1:0]   buf_rdata;
    logic                   buf_full, buf_empty;
    logic [CW-1:0]          buf_count;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (XLEN + ILEN)
    ) u_buffer (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect_valid),
        .push_i  (push),
        .wdata_i ({pc_q, imem_rdata}),
        .pop_i   (pop),
        .rdata_o (buf_rdata),
        .full_o  (buf_full),
        .empty_o (buf_empty),
        .count_o (buf_count)
    );

    assign inst_valid     = !buf_empty;
    assign inst_data      = buf_rdata[ILEN-1:0];
    assign inst_pc        = buf_rdata[XLEN+ILEN-1:ILEN];
    assign op             = inst_data[OP_MSB:OP_LSB];
    assign funct3         = inst_data[FUNCT3_MSB:FUNCT3_LSB];
    assign funct7         = inst_data[FUNCT7_MSB:FUNCT7_LSB];
    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign fetch_misalign = misalign_q;

    assign pop       = inst_valid && inst_ready;
    assign can_issue = (buf_count < CNT_MAX) && !misalign_q;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        addr_d     = addr_q;
        req_d      = req_q;
        misalign_d = misalign_q;
        push       = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (can_issue) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = ST_WAIT;
                end else begin
                    req_d = 1'b0;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    push    = !buf_full;
                    pc_d    = pc_q + PC_STEP;
                    req_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) begin
                    req_d   = 1'b0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = ST_RUN;
            end
        endcase
        // Redirect beats everything: no push, no issue from the old PC, an in-flight request drains.
        if (redirect_valid) begin
            push       = 1'b0;
            pc_d       = redirect_pc;
            misalign_d = |redirect_pc[1:0];
            if (state_q == ST_RUN) begin
                req_d   = 1'b0;
                addr_d  = addr_q;
                state_d = ST_RUN;
            end else if (state_q == ST_WAIT && !imem_rvalid) begin
                state_d = ST_DRAIN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a queue-based fetch model.
module tb_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        imem_rvalid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        fetch_misalign;

    fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_rvalid    (imem_rvalid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .op             (op),
        .funct3         (funct3),
        .funct7         (funct7),
        .fetch_misalign (fetch_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] w;
    } ent_t;

    // Reference model: expected buffer contents and the outstanding-request picture.
    ent_t        m_q[$];
    logic [31:0] m_pc = RST_PC;
    logic        m_out = 1'b0;
    logic        m_drain = 1'b0;
    logic [31:0] m_out_addr = '0;
    logic        m_mis = 1'b0;

    // Memory environment.
    int          mem_cnt = 0;
    int          mem_lat = 1;
    bit          mem_rand = 1'b0;
    logic [31:0] mem_word = 32'h0050_0093;
    bit          stale_rv = 1'b0;
    bit          redir_on_rv = 1'b0;
    logic [31:0] rv_target = '0;
    bit          rv_fired = 1'b0;

    logic [31:0] iss_q[$];
    bit          prev_req = 1'b0;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic rd, input logic [31:0] rpc,
                              input logic rdy, input logic rv, input logic [31:0] rw);
        bit   pop, resp, issue;
        ent_t e;
        if (r) begin
            m_pc = RST_PC;
            m_q.delete();
            m_out = 1'b0;
            m_drain = 1'b0;
            m_mis = 1'b0;
            return;
        end
        pop   = (m_q.size() > 0) && rdy;
        resp  = rv && m_out;
        issue = !m_out && (m_q.size() < DEPTH) && !m_mis && !rd;
        if (rd) begin
            m_q.delete();
            if (m_out && !rv) m_drain = 1'b1;
            else begin
                m_out = 1'b0;
                m_drain = 1'b0;
            end
            m_pc  = rpc;
            m_mis = (rpc % 4) != 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (resp) begin
                if (!m_drain) begin
                    e.pc = m_out_addr;
                    e.w  = rw;
                    m_q.push_back(e);
                    m_pc = m_out_addr + 32'd4;
                end
                m_out = 1'b0;
                m_drain = 1'b0;
            end
            if (issue) begin
                m_out = 1'b1;
                m_out_addr = m_pc;
            end
        end
    endtask

    task automatic compare();
        logic [31:0] w;
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_out});
        if (m_out) chk("imem_addr", imem_addr, m_out_addr);
        chk("inst_valid", {31'd0, inst_valid}, {31'd0, m_q.size() != 0});
        chk("fetch_misalign", {31'd0, fetch_misalign}, {31'd0, m_mis});
        if (m_q.size() != 0) begin
            w = m_q[0].w;
            chk("inst_data", inst_data, w);
            chk("inst_pc", inst_pc, m_q[0].pc);
            chk("op", {25'd0, op}, w % 128);
            chk("funct3", {29'd0, funct3}, (w / 4096) % 8);
            chk("funct7", {25'd0, funct7}, w / 33554432);
        end
    endtask

    task automatic cycle(input logic r, input logic rd, input logic [31:0] rpc, input logic rdy);
        logic        rv;
        logic [31:0] rw;
        rv = 1'b0;
        if (imem_req === 1'b1) begin
            mem_cnt++;
            if (mem_cnt >= mem_lat) begin
                rv = 1'b1;
                mem_cnt = 0;
                if (mem_rand) mem_lat = $urandom_range(1, 3);
            end
        end else begin
            mem_cnt = 0;
            rv = stale_rv;
            stale_rv = 1'b0;
        end
        rw = mem_rand ? $urandom : mem_word;
        if (redir_on_rv && rv) begin
            rd = 1'b1;
            rpc = rv_target;
            redir_on_rv = 1'b0;
            rv_fired = 1'b1;
        end
        rst = r;
        redirect_valid = rd;
        redirect_pc = rpc;
        inst_ready = rdy;
        imem_rvalid = rv;
        imem_rdata = rw;
        model_edge(r, rd, rpc, rdy, rv, rw);
        @(posedge clk);
        #1;
        if (imem_req === 1'b1 && !prev_req) iss_q.push_back(imem_addr);
        prev_req = (imem_req === 1'b1);
        compare();
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, rdy);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        iss_q.delete();
    endtask

    task automatic wait_req(input string tag, input logic rdy);
        for (int i = 0; i < 20 && imem_req !== 1'b1; i++) cycle(1'b0, 1'b0, 32'd0, rdy);
        chk(tag, {31'd0, imem_req}, 32'd1);
    endtask

    function automatic logic [31:0] issue_at(input int i);
        return (iss_q.size() > i) ? iss_q[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        logic        r, rd;
        logic [31:0] rpc;

        // Straight-line fetch with a 1-cycle memory.
        mem_lat = 1;
        do_reset();
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_valid", {31'd0, inst_valid}, 32'd0);
        run(10, 1'b1);
        chk("seq_addr0", issue_at(0), 32'h0);
        chk("seq_addr1", issue_at(1), 32'h4);
        chk("seq_addr2", issue_at(2), 32'h8);

        // Backpressure fills the buffer, then drains one per cycle.
        do_reset();
        run(10, 1'b0);
        chk("bp_req", {31'd0, imem_req}, 32'd0);
        chk("bp_head_pc", inst_pc, 32'h0);
        chk("bp_head_op", {25'd0, op}, 32'h13);
        iss_q.delete();
        run(6, 1'b1);
        chk("bp_next_addr", issue_at(0), 32'h8);

        // Redirect while a slow request is in flight.
        mem_lat = 3;
        wait_req("wait_req_c", 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b1);
        iss_q.delete();
        run(8, 1'b1);
        chk("redir_addr", issue_at(0), 32'h100);

        // Redirect landing on the same cycle as a response.
        mem_lat = 1;
        redir_on_rv = 1'b1;
        rv_target = 32'h200;
        rv_fired = 1'b0;
        for (int i = 0; i < 20 && !rv_fired; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("rv_redirect_fired", {31'd0, rv_fired}, 32'd1);
        chk("rv_redirect_valid", {31'd0, inst_valid}, 32'd0);
        iss_q.delete();
        run(6, 1'b0);
        chk("rv_redirect_addr", issue_at(0), 32'h200);

        // Misaligned target halts fetch until an aligned redirect.
        cycle(1'b0, 1'b1, 32'h102, 1'b1);
        run(5, 1'b1);
        chk("mis_flag", {31'd0, fetch_misalign}, 32'd1);
        chk("mis_noreq", {31'd0, imem_req}, 32'd0);
        cycle(1'b0, 1'b1, 32'h300, 1'b1);
        iss_q.delete();
        run(6, 1'b1);
        chk("mis_clear", {31'd0, fetch_misalign}, 32'd0);
        chk("mis_next_addr", issue_at(0), 32'h300);

        // Reset during an outstanding request, stale response afterwards.
        mem_lat = 3;
        wait_req("wait_req_f", 1'b1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        iss_q.delete();
        stale_rv = 1'b1;
        run(8, 1'b1);
        chk("rst_first_addr", issue_at(0), RST_PC);

        // Random traffic.
        mem_rand = 1'b1;
        mem_lat = $urandom_range(1, 3);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            rd = ($urandom_range(0, 9) == 0);
            rpc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF8;
            if ($urandom_range(0, 4) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 19) == 0) stale_rv = 1'b1;
            cycle(r, rd, rpc, $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
